// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            startE;
  logic [2:0]      opE;
  logic [XLEN-1:0] srcaE;
  logic [XLEN-1:0] srcbE;
  logic [4:0]      rdE;
  logic            flushE;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rdM;

  modport master (
    output startE, opE, srcaE, srcbE, rdE, flushE,
    input  busy, done, result, rdM
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, rdE, flushE,
    output busy, done, result, rdM
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: pipelined multiplier, 1-bit/cycle restoring divider,
// registered busy/done/result/rdM for the hazard unit and M-stage mux.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned PIPE = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam int unsigned CW   = 6;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic [PW-1:0]   r_prod [PIPE];
  logic [PIPE-1:0] r_pvld;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_accept;
  logic            w_ma_sgn;
  logic            w_mb_sgn;
  logic [PW-1:0]   w_a_ext;
  logic [PW-1:0]   w_b_ext;
  logic [PW-1:0]   w_prod;
  logic            w_d_sgn;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_dz;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_fix_res;

  function automatic logic [XLEN-1:0] mul_sel(input logic [PW-1:0] p, input logic [2:0] op);
    return (op == 3'd0) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  assign w_a      = bus.srcaE;
  assign w_b      = bus.srcbE;
  assign w_accept = bus.startE && !bus.flushE;

  // MULH: both signed; MULHSU: rs1 signed only; MUL low half is sign-agnostic
  assign w_ma_sgn = (bus.opE == 3'd1) || (bus.opE == 3'd2);
  assign w_mb_sgn = (bus.opE == 3'd1);
  assign w_a_ext  = {{XLEN{w_ma_sgn & w_a[XLEN-1]}}, w_a};
  assign w_b_ext  = {{XLEN{w_mb_sgn & w_b[XLEN-1]}}, w_b};
  assign w_prod   = w_a_ext * w_b_ext;

  assign w_d_sgn    = ~bus.opE[0];
  assign w_neg_a    = w_d_sgn & w_a[XLEN-1];
  assign w_neg_b    = w_d_sgn & w_b[XLEN-1];
  assign w_abs_a    = w_neg_a ? (XLEN'(0) - w_a) : w_a;
  assign w_abs_b    = w_neg_b ? (XLEN'(0) - w_b) : w_b;
  assign w_dz       = (w_b == '0);
  assign w_ovf      = w_d_sgn && (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1);
  assign w_spec_res = w_dz ? (bus.opE[1] ? w_a : '1) : (bus.opE[1] ? '0 : w_a);

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign w_trial   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_trial - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[XLEN];
  assign w_fix_res = r_op[1] ? (r_neg_r ? (XLEN'(0) - r_rem) : r_rem)
                             : (r_neg_q ? (XLEN'(0) - r_quo) : r_quo);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.rdM    <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      for (int i = 0; i < int'(PIPE); i++) r_prod[i] <= '0;
      r_pvld     <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op <= bus.opE;
            r_rd <= bus.rdE;
            if (!bus.opE[2]) begin
              if (MUL_STAGES == 1) begin
                bus.result <= mul_sel(w_prod, bus.opE);
                bus.rdM    <= bus.rdE;
                bus.done   <= 1'b1;
                bus.busy   <= 1'b0;
                r_state    <= S_DONE;
              end else begin
                r_prod[0] <= w_prod;
                r_pvld    <= PIPE'(1);
                bus.busy  <= 1'b1;
                r_state   <= S_MUL;
              end
            end else if (w_dz || w_ovf) begin
              bus.result <= w_spec_res;
              bus.rdM    <= bus.rdE;
              bus.done   <= 1'b1;
              bus.busy   <= 1'b0;
              r_state    <= S_DONE;
            end else begin
              r_quo    <= w_abs_a;
              r_rem    <= '0;
              r_dvs    <= w_abs_b;
              r_cnt    <= CW'(XLEN - 1);
              r_neg_q  <= w_neg_a ^ w_neg_b;
              r_neg_r  <= w_neg_a;
              bus.busy <= 1'b1;
              r_state  <= S_DIV;
            end
          end else begin
            bus.busy <= 1'b0;
            r_state  <= S_IDLE;
          end
        end

        S_MUL: begin
          if (bus.flushE) begin
            r_pvld   <= '0;
            bus.busy <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            for (int i = 1; i < int'(PIPE); i++) r_prod[i] <= r_prod[i-1];
            r_pvld <= r_pvld << 1;
            if (r_pvld[PIPE-1]) begin
              bus.result <= mul_sel(r_prod[PIPE-1], r_op);
              bus.rdM    <= r_rd;
              bus.done   <= 1'b1;
              bus.busy   <= 1'b0;
              r_state    <= S_DONE;
            end
          end
        end

        S_DIV: begin
          if (bus.flushE) begin
            bus.busy <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_rem <= w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            if (r_cnt == '0) begin
              r_state <= S_FIX;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end

        S_FIX: begin
          bus.busy <= 1'b0;
          if (bus.flushE) begin
            r_state <= S_IDLE;
          end else begin
            bus.result <= w_fix_res;
            bus.rdM    <= r_rd;
            bus.done   <= 1'b1;
            r_state    <= S_DONE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors queue expected result/rd/cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam int          MS   = 2;
  localparam int          DLAT = XLEN + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) bus ();
  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, bus.result, e.res);
        chk({e.name, "_rdM"}, 32'(bus.rdM), 32'(e.rd));
        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called at a negedge: present a start for one cycle, optionally queue its expectation
  task automatic drive(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] ex,
                       input int lat, input bit expect_done);
    exp_t e;
    bus.startE = 1'b1;
    bus.opE    = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    bus.rdE    = rd;
    if (expect_done) begin
      e.name = nm; e.res = ex; e.rd = rd; e.due = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.startE = 1'b0;
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] ex,
                       input int lat, input bit expect_done);
    @(negedge clk);
    drive(nm, op, a, b, rd, ex, lat, expect_done);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || bus.busy || bus.done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("idle_timeout", 32'(n), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    reset      = 1'b0;
    bus.startE = 1'b0;
    bus.opE    = '0;
    bus.srcaE  = '0;
    bus.srcbE  = '0;
    bus.rdE    = '0;
    bus.flushE = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_rdM", 32'(bus.rdM), 32'd0);
    reset = 1'b1;

    // Multiplies
    issue("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, MS, 1); wait_idle();
    issue("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, MS, 1); wait_idle();
    issue("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, MS, 1); wait_idle();
    issue("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd4, 32'hFFFFFFFF, MS, 1); wait_idle();

    // General divides, busy length checked on the first
    begin
      int n = 0;
      issue("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, DLAT, 1);
      while (bus.busy && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("div_busy_cycles", 32'(n), 32'd33);
      wait_idle();
    end
    issue("rem_m7_2",  3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, DLAT, 1); wait_idle();
    issue("divu_100",  3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       DLAT, 1); wait_idle();
    issue("remu_100",  3'd7, 32'd100,      32'd7,        5'd8,  32'd2,        DLAT, 1); wait_idle();
    issue("div_7_m2",  3'd4, 32'd7,        32'hFFFFFFFE, 5'd9,  32'hFFFFFFFD, DLAT, 1); wait_idle();
    issue("rem_7_m2",  3'd6, 32'd7,        32'hFFFFFFFE, 5'd10, 32'd1,        DLAT, 1); wait_idle();

    // Single-cycle special cases
    issue("divu_by0",  3'd5, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1, 1); wait_idle();
    issue("remu_by0",  3'd7, 32'd5,        32'd0,        5'd12, 32'd5,        1, 1); wait_idle();
    issue("div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1, 1); wait_idle();
    issue("rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1, 1); wait_idle();
    issue("rem_m7_by0",3'd6, 32'hFFFFFFF9, 32'd0,        5'd15, 32'hFFFFFFF9, 1, 1); wait_idle();

    // Flush mid-divide, then a multiply right after; result holds in between
    issue("div_flushed", 3'd4, 32'd1000, 32'd3, 5'd30, 32'd0, DLAT, 0);
    repeat (9) @(negedge clk);
    bus.flushE = 1'b1;
    @(negedge clk);
    bus.flushE = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_hold_result", bus.result, 32'hFFFFFFF9);
    drive("mul_3x4", 3'd0, 32'd3, 32'd4, 5'd17, 32'd12, MS, 1);
    chk("mul_after_flush_busy", 32'(bus.busy), 32'd1);
    chk("mul_after_flush_hold", bus.result, 32'hFFFFFFF9);
    wait_idle();

    // Ignored starts while busy, then back-to-back start on the DONE cycle
    begin
      int n = 0;
      issue("divu_b2b", 3'd5, 32'd100, 32'd7, 5'd18, 32'd14, DLAT, 1);
      repeat (3) begin
        bus.startE = 1'b1; bus.opE = 3'd0; bus.srcaE = 32'd9; bus.srcbE = 32'd9; bus.rdE = 5'd31;
        @(negedge clk);
        bus.startE = 1'b0;
        @(negedge clk);
      end
      while (!bus.done && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chk("b2b_done_timeout", 32'(n), 32'd0);
      drive("mul_b2b", 3'd0, 32'd5, 32'd6, 5'd19, 32'd30, MS, 1);
      wait_idle();
    end

    // Flush on the DONE cycle: done still pulses, same-cycle start squashed
    issue("divu_by0_fl", 3'd5, 32'd5, 32'd0, 5'd20, 32'hFFFFFFFF, 1, 1);
    bus.flushE = 1'b1;
    bus.startE = 1'b1; bus.opE = 3'd0; bus.srcaE = 32'd2; bus.srcbE = 32'd2; bus.rdE = 5'd21;
    @(negedge clk);
    bus.flushE = 1'b0;
    bus.startE = 1'b0;
    chk("done_flush_busy", 32'(bus.busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("done_flush_result", bus.result, 32'hFFFFFFFF);
    wait_idle();

    // Reset during divide iteration 5
    issue("div_reset", 3'd4, 32'd1000, 32'd7, 5'd22, 32'd0, DLAT, 0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_rdM", 32'(bus.rdM), 32'd0);
    issue("divu_9_3", 3'd5, 32'd9, 32'd3, 5'd23, 32'd3, DLAT, 1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Execute-stage RV32M/RV64M multiply/divide unit for the pipelined core. It sits beside the ALU and shifter and takes the same forwarded operands. Multiplies use a MUL_STAGES-deep pipelined datapath; divides and remainders use an iterative 1-bit/cycle FSM. It raises busy so the hazard unit can stall F/D/E, and reports completion with a one-cycle done pulse plus result and destination register for the M-stage mux.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_STAGES, 2, multiply latency in cycles (legal 1..4)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on clk edge)
startE  in  1  request; accepted only when busy==0 and flushE==0
opE  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
srcaE  in  XLEN  rs1 operand (post-forwarding)
srcbE  in  XLEN  rs2 operand (post-forwarding)
rdE  in  5  destination register
flushE  in  1  abort in-flight op, squash same-cycle start
busy  out  1  op in flight; hazard unit stalls while high
done  out  1  one-cycle pulse, result/rd valid
result  out  XLEN  product/quotient/remainder
rdM  out  5  rd of completing op

Behaviour:
- Reset (reset==0): state IDLE; busy=0, done=0, result=0, rdM=0; all internal pipeline/iteration registers cleared. Reset mid-operation discards the op, with no done.
- States: IDLE, MUL, DIV, FIX, DONE. busy=1 in MUL, DIV, FIX; busy=0 in IDLE, DONE.
- Accept: in IDLE or DONE, startE=1 and flushE=0 latches opE, srcaE, srcbE, rdE. startE while busy is ignored; the in-flight op is undisturbed.
- MUL path: sign/zero extend operands to 2*XLEN per op (MULHSU: rs1 signed, rs2 unsigned). MUL returns low XLEN bits; MULH* return high XLEN bits. Product is staged through MUL_STAGES registers. done is asserted exactly MUL_STAGES cycles after the accept edge.
- DIV path, special cases resolved in one cycle (done 1 cycle after accept):
  - divisor==0: quotient = all ones, remainder = dividend (signed and unsigned).
  - signed overflow (dividend = -2^(XLEN-1), divisor = -1): quotient = dividend, remainder = 0.
- DIV path, general case:
  - Take absolute values for signed ops.
  - XLEN restoring iterations in DIV, with a 6-bit iteration counter counting XLEN-1 down to 0.
  - One FIX cycle negates the quotient if operand signs differ; negates the remainder if the dividend is negative.
  - done is asserted XLEN+2 cycles after accept (34 for XLEN=32).
- DONE: done=1 for exactly one cycle; result and rdM are valid. Next state is IDLE, or MUL/DIV if a new start is accepted that cycle (back-to-back allowed).
- result and rdM hold their last completed values until the next done. They are not cleared by flush.
- flushE=1 while busy: the next state is IDLE, no done is produced for the aborted op, and busy=0 on the following cycle.
- flushE=1 in DONE: done still pulses (the op has already completed), and any same-cycle start is squashed.
- Iteration counter and product stage valids never wrap. The counter saturates at 0 and the FSM leaves DIV on counter==0.

Test Plan:
- MUL, XLEN=32, MUL_STAGES=2: srcaE=7, srcbE=0xFFFFFFFD → done exactly 2 cycles after accept, result=0xFFFFFFEB; then MULH 0x80000000*0x80000000 → 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 → 0xFFFFFFFF.
- DIV/REM signed: DIV -7/2 → 0xFFFFFFFD at accept+34, busy high for 33 cycles; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2.
- Special cases: DIVU 5/0 → 0xFFFFFFFF at accept+1; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Flush/abort: start DIV, assert flushE on cycle 10 → busy=0 on cycle 11, no done; MUL 3*4 started on cycle 11 → done with 12; result keeps the prior value in between.
- Back-to-back and ignored start: start MUL on the DONE cycle of a DIV → both complete, each with its correct rdM; startE pulses while busy → no effect on result or timing.
- Reset mid-op: reset=0 for one cycle during DIV iteration 5 → busy=0, done=0, result=0, rdM=0 next cycle; a subsequent DIVU 9/3 → 3 at accept+34.
